// File: rtl/debounce_sync_pkg.sv
// Shared definitions for the single-bit input-conditioning blocks:
// default parameters, counter sizing helper, FSM state and status payload.
package debounce_sync_pkg;

    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_STABLE_CYCLES = 8;

    // Ceiling log2, used to size qualification counters.
    function automatic int unsigned clog2_ceil(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned DEF_CNT_W = clog2_ceil(DEF_STABLE_CYCLES);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    typedef struct packed {
        logic dout;
        logic rise;
        logic fall;
        logic busy;
    } status_t;

endpackage

// File: rtl/debounce_sync_if.sv
// Conditioned-input bundle: raw input towards the debouncer, clean level
// and edge/qualification status back from it.
interface debounce_sync_if;

    logic din;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output din,
        input  dout,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  din,
        output dout,
        output rise,
        output fall,
        output busy
    );

endinterface

// File: rtl/debounce_sync_sync_chain.sv
// N-stage single-bit synchroniser; plain flops with async active-high reset
// to 0 and nothing between stages, so only stage 1 can go metastable.
module debounce_sync_sync_chain #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[N-2:0], d};
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronises and debounces a raw asynchronous input, producing a clean
// level plus single-cycle rise/fall pulses and a qualification-busy flag.
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    debounce_sync_if.slave  bus
);

    // The commit fires on the edge that would take cnt to STABLE_CYCLES-1,
    // giving dout a change SYNC_STAGES+STABLE_CYCLES-1 edges after capture.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

    logic             s_out;
    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    status_t          status_q;
    status_t          status_n;
    logic             mismatch;
    logic             expire;

    debounce_sync_sync_chain #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.din),
        .q   (s_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            status_q <= status_n;
        end
    end

    always_comb begin
        state_n       = state_q;
        cnt_n         = '0;
        status_n      = '0;
        status_n.dout = status_q.dout;
        mismatch      = (s_out != status_q.dout);
        expire        = (cnt_q == CNT_LAST);

        case (state_q)
            ST_STABLE: begin
                if (mismatch) begin
                    if (expire) begin
                        status_n.dout = s_out;
                        status_n.rise = s_out;
                        status_n.fall = ~s_out;
                    end else begin
                        cnt_n   = cnt_q + CNT_W'(1);
                        state_n = ST_QUALIFY;
                    end
                end
            end
            ST_QUALIFY: begin
                // Any agreeing cycle aborts: qualification restarts from zero.
                if (!mismatch) begin
                    state_n = ST_STABLE;
                end else if (expire) begin
                    status_n.dout = s_out;
                    status_n.rise = s_out;
                    status_n.fall = ~s_out;
                    state_n       = ST_STABLE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_STABLE;
            end
        endcase

        status_n.busy = (cnt_n != '0);
    end

    assign bus.dout = status_q.dout;
    assign bus.rise = status_q.rise;
    assign bus.fall = status_q.fall;
    assign bus.busy = status_q.busy;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: a per-edge reference model pushes the
// expected outputs to a scoreboard that is popped when the DUT is sampled.
module tb_debounce_sync;

    localparam int unsigned SS = 2;
    localparam int unsigned SC = 8;

    typedef struct packed {
        logic dout;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    logic clk;
    logic rst;
    debounce_sync_if bus ();

    debounce_sync #(
        .SYNC_STAGES   (SS),
        .STABLE_CYCLES (SC),
        .CNT_W         (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t          sb[$];
    int            n_assert = 0;
    int            n_fail   = 0;
    logic [SS-1:0] m_sync;
    int            m_run;
    logic          m_dout;
    logic          m_rise;
    logic          m_fall;
    int            edge_n;
    int            rise_n;
    int            fall_n;
    int            rise_at;
    int            fall_at;
    int            busy_at;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sync = '0;
        m_run  = 0;
        m_dout = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
    endtask

    // One rising edge of the reference: qualify on the old s_out, then shift.
    task automatic model_edge();
        logic s;
        s      = m_sync[SS-1];
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_dout) begin
            if (m_run + 1 == int'(SC) - 1) begin
                m_dout = s;
                m_rise = s;
                m_fall = ~s;
                m_run  = 0;
            end else begin
                m_run++;
            end
        end else begin
            m_run = 0;
        end
        m_sync = {m_sync[SS-2:0], bus.din};
    endtask

    task automatic phase_start();
        edge_n  = 0;
        rise_n  = 0;
        fall_n  = 0;
        rise_at = -1;
        fall_at = -1;
        busy_at = -1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".dout"}, bus.dout, 1'b0);
        chk({tag, ".rise"}, bus.rise, 1'b0);
        chk({tag, ".fall"}, bus.fall, 1'b0);
        chk({tag, ".busy"}, bus.busy, 1'b0);
    endtask

    // Drive din, take one edge, push the model result, sample 1 time unit later.
    task automatic step(input logic v, input string tag);
        exp_t e;
        bus.din = v;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        sb.push_back('{dout: m_dout, rise: m_rise, fall: m_fall, busy: (m_run != 0)});
        #1;
        e = sb.pop_front();
        chk({tag, ".dout"}, bus.dout, e.dout);
        chk({tag, ".rise"}, bus.rise, e.rise);
        chk({tag, ".fall"}, bus.fall, e.fall);
        chk({tag, ".busy"}, bus.busy, e.busy);
        chk({tag, ".excl"}, bus.rise & bus.fall, 1'b0);
        edge_n++;
        if (bus.rise === 1'b1) begin
            rise_n++;
            if (rise_at < 0) rise_at = edge_n;
        end
        if (bus.fall === 1'b1) begin
            fall_n++;
            if (fall_at < 0) fall_at = edge_n;
        end
        if (bus.busy === 1'b1 && busy_at < 0) busy_at = edge_n;
    endtask

    initial begin
        rst     = 1'b0;
        bus.din = 1'b0;
        model_reset();
        phase_start();

        // Reset applied between edges takes effect with no clock.
        #3;
        rst     = 1'b1;
        bus.din = 1'b1;
        #1;
        check_zero("reset_async");
        for (int i = 0; i < 3; i++) step(1'b0, "reset_hold");

        // Clean rise.
        rst = 1'b0;
        phase_start();
        for (int i = 0; i < 12; i++) step(1'b1, "rise");
        chk_int("rise.busy_first_edge", busy_at, 3);
        chk_int("rise.rise_edge", rise_at, 9);
        chk_int("rise.rise_count", rise_n, 1);
        chk_int("rise.fall_count", fall_n, 0);

        // Clean fall.
        phase_start();
        for (int i = 0; i < 12; i++) step(1'b0, "fall");
        chk_int("fall.fall_edge", fall_at, 9);
        chk_int("fall.fall_count", fall_n, 1);
        chk_int("fall.rise_count", rise_n, 0);

        // Bounce: 5 high, 1 low, then held high; final capture is edge 7.
        phase_start();
        for (int i = 0; i < 5; i++) step(1'b1, "bounce_a");
        step(1'b0, "bounce_gap");
        for (int i = 0; i < 14; i++) step(1'b1, "bounce_b");
        chk_int("bounce.rise_edge", rise_at, 15);
        chk_int("bounce.rise_count", rise_n, 1);

        phase_start();
        for (int i = 0; i < 12; i++) step(1'b0, "bounce_fall");
        chk_int("bounce_fall.fall_count", fall_n, 1);

        // Short pulse too brief to qualify.
        phase_start();
        for (int i = 0; i < 6; i++) step(1'b1, "short_hi");
        for (int i = 0; i < 10; i++) step(1'b0, "short_lo");
        chk_int("short.rise_count", rise_n, 0);
        chk_int("short.fall_count", fall_n, 0);
        chk_int("short.busy_seen", busy_at > 0 ? 1 : 0, 1);
        chk("short.busy_end", bus.busy, 1'b0);
        chk("short.dout_end", bus.dout, 1'b0);

        // Reset in the middle of qualification (counter at 4 after edge 6).
        phase_start();
        for (int i = 0; i < 6; i++) step(1'b1, "mid_qual");
        chk("mid_qual.busy_before", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        model_reset();
        check_zero("mid_reset");
        for (int i = 0; i < 2; i++) step(1'b1, "mid_reset_hold");
        rst = 1'b0;
        phase_start();
        for (int i = 0; i < 12; i++) step(1'b1, "after_reset");
        chk_int("after_reset.rise_edge", rise_at, 9);
        chk_int("after_reset.rise_count", rise_n, 1);
        chk_int("after_reset.fall_count", fall_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
